// File: rtl/hough_seq_pkg.sv
// Shared state encoding and datapath widths for the Hough frame sequencer.
// Width constants size the pixel bus and the column/row index counters.
package hough_seq_pkg;

    localparam int PIX_W = 8;
    localparam int IDX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

endpackage

// File: rtl/hough_seq_blank_cnt.sv
// Loadable down-counter timing the horizontal and vertical blanking intervals.
// Load with N-1 on entry; o_zero marks the final blanking cycle.
module hough_seq_blank_cnt
    import hough_seq_pkg::*;
(
    input  logic             Clk,
    input  logic             nReset,
    input  logic             i_load,
    input  logic [IDX_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [IDX_W-1:0] r_cnt;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hough_seq.sv
// Frame/line sequencer feeding a Hough core; optional FrameCnt via HOUGH_SEQ_FRAME_CNT_EN.
// Latency: Pixel/PixValid/i/j registered, valid 1 cycle after accept.
// Backpressure: SrcReady high only in ACTIVE; SrcValid=0 stalls without counter change.
module hough_seq
    import hough_seq_pkg::*;
#(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 128,
    parameter int HBLANK = 4,
    parameter int VBLANK = 16
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             Enable,
    input  logic [PIX_W-1:0] PixelSrc,
    input  logic             SrcValid,
    output logic             SrcReady,
    output logic [PIX_W-1:0] Pixel,
    output logic             PixValid,
    output logic             Frame,
    output logic             Line,
    output logic [IDX_W-1:0] i,
    output logic [IDX_W-1:0] j,
`ifdef HOUGH_SEQ_FRAME_CNT_EN
    output logic [7:0]       FrameCnt,
`endif
    output logic             FrameDone
);

    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(HEIGHT - 1);
    localparam logic [IDX_W-1:0] HB_LOAD  = (HBLANK > 0) ? IDX_W'(HBLANK - 1) : '0;
    localparam logic [IDX_W-1:0] VB_LOAD  = IDX_W'(VBLANK - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_col;
    logic [IDX_W-1:0] r_row;
    logic [PIX_W-1:0] r_pixel;
    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;
    logic             r_pix_vld;
    logic             r_frame;
    logic             r_line;
    logic             r_frame_done;

    logic             w_accept;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_line_end;
    logic             w_frame_end;
    logic             w_blank_zero;

    assign w_accept    = SrcValid & (r_state == ST_ACTIVE);
    assign w_last_col  = (r_col == LAST_COL);
    assign w_last_row  = (r_row == LAST_ROW);
    assign w_line_end  = w_accept & w_last_col;
    assign w_frame_end = w_line_end & w_last_row;

    hough_seq_blank_cnt u_blank_cnt (
        .Clk        (Clk),
        .nReset     (nReset),
        .i_load     (w_line_end),
        .i_load_val (w_last_row ? VB_LOAD : HB_LOAD),
        .o_zero     (w_blank_zero)
    );

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Enable is only sampled in IDLE and at VBLANK exit, so a frame never truncates.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (Enable) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                if (w_frame_end)                     w_state_nxt = ST_VBLANK;
                else if (w_line_end && (HBLANK > 0)) w_state_nxt = ST_HBLANK;
            end
            ST_HBLANK: if (w_blank_zero) w_state_nxt = ST_ACTIVE;
            ST_VBLANK: if (w_blank_zero) w_state_nxt = Enable ? ST_ACTIVE : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Counters clear at the frame's last accept, so VBLANK exit starts at (0,0).
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_pixel      <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_pix_vld    <= 1'b0;
            r_frame      <= 1'b0;
            r_line       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_pix_vld    <= w_accept;
            r_frame      <= w_accept & (r_col == '0) & (r_row == '0);
            r_line       <= w_accept & (r_col == '0);
            r_frame_done <= w_frame_end;
            if (w_accept) begin
                r_pixel <= PixelSrc;
                r_i     <= r_col;
                r_j     <= r_row;
            end
        end
    end

`ifdef HOUGH_SEQ_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_frame_cnt <= '0;
        end else if (w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign FrameCnt = r_frame_cnt;
`endif

    assign SrcReady  = (r_state == ST_ACTIVE);
    assign Pixel     = r_pixel;
    assign PixValid  = r_pix_vld;
    assign Frame     = r_frame;
    assign Line      = r_line;
    assign i         = r_i;
    assign j         = r_j;
    assign FrameDone = r_frame_done;

endmodule

// File: tb/tb_hough_seq.sv
// Bench for hough_seq at 4x3 pixels: cycle-pattern table, pixel scoreboard, corner sequences.
// A second instance with HBLANK=0 covers back-to-back lines; FrameCnt tested if its macro is set.
module tb_hough_seq;

    localparam int W = 4;
    localparam int H = 3;

    logic       Clk;
    logic       nReset, Enable, SrcValid;
    logic [7:0] PixelSrc;
    logic       SrcReady, PixValid, Frame, Line, FrameDone;
    logic [7:0] Pixel, i, j;

    logic       nReset0, Enable0, SrcValid0;
    logic       SrcReady0, PixValid0, Frame0, Line0, FrameDone0;
    logic [7:0] Pixel0, i0, j0;
`ifdef HOUGH_SEQ_FRAME_CNT_EN
    logic [7:0] FrameCnt, FrameCnt0;
`endif

    hough_seq #(.WIDTH(W), .HEIGHT(H), .HBLANK(2), .VBLANK(3)) u_dut (
        .Clk(Clk), .nReset(nReset), .Enable(Enable), .PixelSrc(PixelSrc),
        .SrcValid(SrcValid), .SrcReady(SrcReady), .Pixel(Pixel), .PixValid(PixValid),
        .Frame(Frame), .Line(Line), .i(i), .j(j),
`ifdef HOUGH_SEQ_FRAME_CNT_EN
        .FrameCnt(FrameCnt),
`endif
        .FrameDone(FrameDone)
    );

    hough_seq #(.WIDTH(W), .HEIGHT(H), .HBLANK(0), .VBLANK(3)) u_dut0 (
        .Clk(Clk), .nReset(nReset0), .Enable(Enable0), .PixelSrc(PixelSrc),
        .SrcValid(SrcValid0), .SrcReady(SrcReady0), .Pixel(Pixel0), .PixValid(PixValid0),
        .Frame(Frame0), .Line(Line0), .i(i0), .j(j0),
`ifdef HOUGH_SEQ_FRAME_CNT_EN
        .FrameCnt(FrameCnt0),
`endif
        .FrameDone(FrameDone0)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_total = 0;
    int n_bad   = 0;
    int n_pix   = 0;
    int n_fd    = 0;
    bit tog     = 1'b0;
    logic [7:0] last_i, last_j;
    logic [25:0] sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
        PixelSrc = PixelSrc + 8'd29;
        if (tog) SrcValid = ~SrcValid;
    endtask

    task automatic wait_px(input int wi, input int wj, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            cyc();
            if (PixValid && (wi < 0 || (i == 8'(wi) && j == 8'(wj)))) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        nReset = 1'b0; Enable = 1'b0; SrcValid = 1'b0; tog = 1'b0;
        cyc(); cyc();
        nReset = 1'b1;
    endtask

    // Reference model: expected {Pixel,i,j,Frame,Line} pushed at each accept.
    initial begin
        int mcol, mrow;
        mcol = 0; mrow = 0;
        forever begin
            @(posedge Clk or negedge nReset);
            if (!nReset) begin
                mcol = 0; mrow = 0;
                sb.delete();
            end else if (SrcValid && SrcReady) begin
                sb.push_back({PixelSrc, 8'(mcol), 8'(mrow), (mcol == 0 && mrow == 0), (mcol == 0)});
                if (mcol == W - 1) begin
                    mcol = 0;
                    mrow = (mrow == H - 1) ? 0 : mrow + 1;
                end else begin
                    mcol = mcol + 1;
                end
            end
        end
    end

    initial begin
        logic [25:0] exp_v;
        forever begin
            @(negedge Clk);
            if (nReset) begin
                if (PixValid) begin
                    n_pix++;
                    last_i = i;
                    last_j = j;
                    n_total++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL sb_unexpected actual=(%0d,%0d) required=no pixel t=%0t", i, j, $time);
                    end else begin
                        exp_v = sb.pop_front();
                        if ({Pixel, i, j, Frame, Line} !== exp_v) begin
                            n_bad++;
                            $display("FAIL sb_pixel actual=%h required=%h t=%0t",
                                     {Pixel, i, j, Frame, Line}, exp_v, $time);
                        end
                    end
                end else begin
                    chk("idle_frame_line", {30'd0, Frame, Line}, 32'd0);
                end
                if (FrameDone) n_fd++;
            end
        end
    end

    typedef struct {
        logic src;
        logic vld;
        logic rdy;
        logic fd;
    } vec_t;

    vec_t tbl[23];

    initial begin
        logic [22:0] vpat;
        bit ok;

        vpat = 23'b1111_00_1111_00_1111_000_1111;
        for (int k = 0; k < 23; k++) begin
            tbl[k].src = 1'b1;
            tbl[k].vld = vpat[22-k];
            tbl[k].rdy = (k < 22) ? vpat[21-k] : 1'b0;
            tbl[k].fd  = (k == 15);
        end

        PixelSrc = 8'h11; Enable = 1'b0; SrcValid = 1'b0;
        Enable0 = 1'b0; SrcValid0 = 1'b0;
        nReset = 1'b1; nReset0 = 1'b1;
        #1;
        nReset = 1'b0; nReset0 = 1'b0;
        #1;
        chk("rst_ready", {31'd0, SrcReady}, 32'd0);
        chk("rst_pixel", {24'd0, Pixel}, 32'd0);
        chk("rst_flags", {28'd0, PixValid, Frame, Line, FrameDone}, 32'd0);
        chk("rst_ij", {16'd0, i, j}, 32'd0);
        chk("rst0_all", {3'd0, SrcReady0, Pixel0, PixValid0, Frame0, Line0, i0, j0, FrameDone0}, 32'd0);

        cyc();
        nReset0 = 1'b1;
        do_reset();

        // Continuous streaming: cycle-exact PixValid/SrcReady/FrameDone pattern.
        Enable = 1'b1; SrcValid = 1'b1;
        wait_px(-1, 0, 20, ok);
        chk("to_first_pix", {31'd0, ok}, 32'd1);
        for (int k = 0; k < 23; k++) begin
            if (k > 0) begin
                SrcValid = tbl[k].src;
                cyc();
            end
            chk($sformatf("tbl_vld[%0d]", k), {31'd0, PixValid}, {31'd0, tbl[k].vld});
            chk($sformatf("tbl_rdy[%0d]", k), {31'd0, SrcReady}, {31'd0, tbl[k].rdy});
            chk($sformatf("tbl_fd[%0d]", k), {31'd0, FrameDone}, {31'd0, tbl[k].fd});
        end

        // SrcValid toggling: scoreboard confirms no skipped or repeated index.
        do_reset();
        n_pix = 0; n_fd = 0;
        Enable = 1'b1; SrcValid = 1'b1; tog = 1'b1;
        for (int k = 0; k < 200 && n_fd == 0; k++) cyc();
        chk("tog_fd", n_fd, 32'd1);
        chk("tog_npix", n_pix, 32'd12);
        chk("tog_last", {16'd0, last_i, last_j}, {16'd0, 8'd3, 8'd2});

        // Enable dropped mid-frame: frame completes, then IDLE.
        do_reset();
        Enable = 1'b1; SrcValid = 1'b1;
        wait_px(1, 1, 50, ok);
        chk("to_pix_1_1", {31'd0, ok}, 32'd1);
        Enable = 1'b0; n_pix = 0; n_fd = 0;
        for (int k = 0; k < 40; k++) cyc();
        chk("en_npix", n_pix, 32'd7);
        chk("en_fd", n_fd, 32'd1);
        chk("en_last", {16'd0, last_i, last_j}, {16'd0, 8'd3, 8'd2});
        chk("en_idle_rdy", {31'd0, SrcReady}, 32'd0);
        chk("en_sb_empty", sb.size(), 32'd0);

        // Reset mid-frame: asynchronous clear, restart at (0,0) with Frame.
        do_reset();
        Enable = 1'b1; SrcValid = 1'b1;
        wait_px(2, 1, 50, ok);
        chk("to_pix_2_1", {31'd0, ok}, 32'd1);
        nReset = 1'b0;
        #1;
        chk("mid_rst_all", {3'd0, SrcReady, Pixel, PixValid, Frame, Line, i, j, FrameDone}, 32'd0);
        cyc(); cyc();
        nReset = 1'b1;
        wait_px(-1, 0, 20, ok);
        chk("to_restart", {31'd0, ok}, 32'd1);
        chk("restart_px", {14'd0, i, j, Frame, Line}, {14'd0, 8'd0, 8'd0, 1'b1, 1'b1});

        // HBLANK=0 instance: next line's first pixel directly follows.
        Enable0 = 1'b1; SrcValid0 = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            cyc();
            if (PixValid0 && i0 == 8'd3 && j0 == 8'd0) ok = 1'b1;
        end
        chk("to_hb0_3_0", {31'd0, ok}, 32'd1);
        cyc();
        chk("hb0_next", {14'd0, PixValid0, i0, j0, Line0}, {14'd0, 1'b1, 8'd0, 8'd1, 1'b1});
        Enable0 = 1'b0; SrcValid0 = 1'b0;

`ifdef HOUGH_SEQ_FRAME_CNT_EN
        do_reset();
        Enable = 1'b1; SrcValid = 1'b1; n_fd = 0;
        for (int k = 0; k < 6000 && n_fd < 257; k++) cyc();
        chk("fc_frames", n_fd, 32'd257);
        cyc();
        chk("fc_value", {24'd0, FrameCnt}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
